// File: rtl/sparse_layer_scheduler_pkg.sv
// Shared types and descriptor layout for the sparse layer scheduler.
package sparse_layer_scheduler_pkg;

    // Scheduler sequencing states, one output row per FETCH..EMIT pass.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_DESC,
        ST_LAUNCH,
        ST_RUN,
        ST_EMIT,
        ST_FINISH
    } sls_state_e;

    // Pair-count field width is fixed by the engine interface.
    localparam int unsigned NNZ_WIDTH = 16;

    // Descriptor word is {weight_base, nnz_pairs, tail_idx, scale}, MSB first.
    function automatic int unsigned desc_width(input int unsigned aw,
                                               input int unsigned iw,
                                               input int unsigned sw);
        return aw + NNZ_WIDTH + iw + sw;
    endfunction

    function automatic int unsigned desc_scale_lsb();
        return 0;
    endfunction

    function automatic int unsigned desc_tail_lsb(input int unsigned sw);
        return sw;
    endfunction

    function automatic int unsigned desc_nnz_lsb(input int unsigned iw,
                                                 input int unsigned sw);
        return iw + sw;
    endfunction

    function automatic int unsigned desc_base_lsb(input int unsigned iw,
                                                  input int unsigned sw);
        return NNZ_WIDTH + iw + sw;
    endfunction

    // Default-geometry descriptor width (12 + 16 + 12 + 24 bits).
    localparam int unsigned DESC_WIDTH = desc_width(12, 12, 24);

    // True when ReLU is enabled and the signed result is negative.
    function automatic logic relu_clamp(input logic relu_en, input logic sign_bit);
        return relu_en && sign_bit;
    endfunction

endpackage

// File: rtl/sparse_layer_scheduler_watchdog.sv
// Row watchdog: cleared at engine launch, counts while the row runs and
// flags expiry when the count reaches TIMEOUT_CYCLES-1.
module sls_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;

    // Expiry is judged on the value the counter is about to reach, so the row
    // spends TIMEOUT_CYCLES-1 cycles in RUN and EMIT follows TIMEOUT_CYCLES
    // cycles after the start pulse.
    always_comb begin
        cnt_inc = cnt_q + ONE;
        expired = enable && (cnt_inc >= LIMIT);
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_inc;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sparse_layer_scheduler.sv
// Sparse FC layer scheduler: fetches per-row descriptors, launches the sparse
// dot-product engine, applies optional ReLU and streams one result per row.
module sparse_layer_scheduler
    import sparse_layer_scheduler_pkg::*;
#(
    parameter int unsigned ROW_WIDTH      = 10,
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned INDEX_WIDTH    = 12,
    parameter int unsigned SCALE_WIDTH    = 24,
    parameter int unsigned ACC_WIDTH      = 48,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned RELU_EN        = 1
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                layer_start,
    input  logic [ROW_WIDTH-1:0]                                num_rows,
    input  logic                                                abort,
    output logic                                                busy,
    output logic                                                layer_done,
    output logic                                                timeout_err,
    output logic [ROW_WIDTH-1:0]                                desc_addr,
    output logic                                                desc_rd,
    input  logic [ADDR_WIDTH+NNZ_WIDTH+INDEX_WIDTH+SCALE_WIDTH-1:0] desc_data,
    output logic                                                eng_start,
    output logic [ADDR_WIDTH-1:0]                               eng_weight_base,
    output logic [NNZ_WIDTH-1:0]                                eng_nnz_pairs,
    output logic [INDEX_WIDTH-1:0]                              eng_tail_idx,
    output logic [SCALE_WIDTH-1:0]                              eng_scale,
    input  logic                                                eng_done,
    input  logic [ACC_WIDTH-1:0]                                eng_acc_dequant,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic [ACC_WIDTH-1:0]                                out_data,
    output logic [ROW_WIDTH-1:0]                                out_row,
    output logic                                                out_err
);

    localparam int unsigned SCALE_LSB = desc_scale_lsb();
    localparam int unsigned TAIL_LSB  = desc_tail_lsb(SCALE_WIDTH);
    localparam int unsigned NNZ_LSB   = desc_nnz_lsb(INDEX_WIDTH, SCALE_WIDTH);
    localparam int unsigned BASE_LSB  = desc_base_lsb(INDEX_WIDTH, SCALE_WIDTH);
    localparam logic [ROW_WIDTH-1:0] ROW_ONE = ROW_WIDTH'(1);

    sls_state_e             state_q, state_d;
    logic [ROW_WIDTH-1:0]   num_rows_q, num_rows_d;
    logic [ROW_WIDTH-1:0]   row_q, row_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [NNZ_WIDTH-1:0]   nnz_q, nnz_d;
    logic [INDEX_WIDTH-1:0] tail_q, tail_d;
    logic [SCALE_WIDTH-1:0] scale_q, scale_d;
    logic [ACC_WIDTH-1:0]   out_data_q, out_data_d;
    logic                   out_err_q, out_err_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   zero_done_q, zero_done_d;

    logic                   wd_clear;
    logic                   wd_enable;
    logic                   wd_expired;
    logic [NNZ_WIDTH-1:0]   desc_nnz;

    assign desc_nnz = desc_data[NNZ_LSB +: NNZ_WIDTH];

    sls_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    // Next-state and datapath update for the row sequencer.
    always_comb begin
        state_d       = state_q;
        num_rows_d    = num_rows_q;
        row_d         = row_q;
        base_d        = base_q;
        nnz_d         = nnz_q;
        tail_d        = tail_q;
        scale_d       = scale_q;
        out_data_d    = out_data_q;
        out_err_d     = out_err_q;
        timeout_err_d = timeout_err_q;
        zero_done_d   = 1'b0;
        wd_clear      = 1'b0;
        wd_enable     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (layer_start) begin
                    if (num_rows != '0) begin
                        num_rows_d    = num_rows;
                        timeout_err_d = 1'b0;
                        row_d         = '0;
                        state_d       = ST_FETCH;
                    end else begin
                        // Empty layer completes without ever becoming busy.
                        zero_done_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT_DESC;
            end
            ST_WAIT_DESC: begin
                base_d  = desc_data[BASE_LSB +: ADDR_WIDTH];
                nnz_d   = desc_nnz;
                tail_d  = desc_data[TAIL_LSB +: INDEX_WIDTH];
                scale_d = desc_data[SCALE_LSB +: SCALE_WIDTH];
                if (desc_nnz == '0) begin
                    out_data_d = '0;
                    out_err_d  = 1'b0;
                    state_d    = ST_EMIT;
                end else begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wd_clear = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                wd_enable = 1'b1;
                if (eng_done) begin
                    out_data_d = relu_clamp(RELU_EN != 0, eng_acc_dequant[ACC_WIDTH-1])
                                 ? '0 : eng_acc_dequant;
                    out_err_d  = 1'b0;
                    state_d    = ST_EMIT;
                end else if (wd_expired) begin
                    out_data_d    = '0;
                    out_err_d     = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (row_q == (num_rows_q - ROW_ONE)) begin
                        state_d = ST_FINISH;
                    end else begin
                        row_d   = row_q + ROW_ONE;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything; the sticky error flag keeps its value
        // even if a layer_start or watchdog expiry coincides.
        if (abort) begin
            state_d       = ST_IDLE;
            zero_done_d   = 1'b0;
            timeout_err_d = timeout_err_q;
        end
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            num_rows_q    <= '0;
            row_q         <= '0;
            base_q        <= '0;
            nnz_q         <= '0;
            tail_q        <= '0;
            scale_q       <= '0;
            out_data_q    <= '0;
            out_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            zero_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_rows_q    <= num_rows_d;
            row_q         <= row_d;
            base_q        <= base_d;
            nnz_q         <= nnz_d;
            tail_q        <= tail_d;
            scale_q       <= scale_d;
            out_data_q    <= out_data_d;
            out_err_q     <= out_err_d;
            timeout_err_q <= timeout_err_d;
            zero_done_q   <= zero_done_d;
        end
    end

    // Output decode from state and held registers.
    always_comb begin
        busy            = (state_q != ST_IDLE) && (state_q != ST_FINISH);
        layer_done      = (state_q == ST_FINISH) || zero_done_q;
        timeout_err     = timeout_err_q;
        desc_rd         = (state_q == ST_FETCH);
        desc_addr       = row_q;
        eng_start       = (state_q == ST_LAUNCH);
        eng_weight_base = base_q;
        eng_nnz_pairs   = nnz_q;
        eng_tail_idx    = tail_q;
        eng_scale       = scale_q;
        out_valid       = (state_q == ST_EMIT);
        out_data        = out_data_q;
        out_row         = row_q;
        out_err         = out_err_q;
    end

endmodule

// File: tb/tb_sparse_layer_scheduler.sv
// Directed, table-driven bench for sparse_layer_scheduler with a small
// descriptor memory and a fixed-latency engine model that can be told to hang.
module tb_sparse_layer_scheduler;

    localparam int unsigned RW   = 10;
    localparam int unsigned AW   = 12;
    localparam int unsigned IW   = 12;
    localparam int unsigned SW   = 24;
    localparam int unsigned ACCW = 48;
    localparam int unsigned TO   = 16;
    localparam int unsigned DW   = AW + 16 + IW + SW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            layer_start = 1'b0;
    logic [RW-1:0]   num_rows = '0;
    logic            abort = 1'b0;
    logic            busy, layer_done, timeout_err;
    logic [RW-1:0]   desc_addr;
    logic            desc_rd;
    logic [DW-1:0]   desc_data = '0;
    logic            eng_start;
    logic [AW-1:0]   eng_weight_base;
    logic [15:0]     eng_nnz_pairs;
    logic [IW-1:0]   eng_tail_idx;
    logic [SW-1:0]   eng_scale;
    logic            eng_done = 1'b0;
    logic [ACCW-1:0] eng_acc_dequant = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [ACCW-1:0] out_data;
    logic [RW-1:0]   out_row;
    logic            out_err;

    sparse_layer_scheduler #(
        .ROW_WIDTH(RW), .ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .SCALE_WIDTH(SW),
        .ACC_WIDTH(ACCW), .TIMEOUT_CYCLES(TO), .RELU_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .layer_start(layer_start), .num_rows(num_rows),
        .abort(abort), .busy(busy), .layer_done(layer_done),
        .timeout_err(timeout_err), .desc_addr(desc_addr), .desc_rd(desc_rd),
        .desc_data(desc_data), .eng_start(eng_start),
        .eng_weight_base(eng_weight_base), .eng_nnz_pairs(eng_nnz_pairs),
        .eng_tail_idx(eng_tail_idx), .eng_scale(eng_scale),
        .eng_done(eng_done), .eng_acc_dequant(eng_acc_dequant),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Descriptor memory: data valid the cycle after desc_rd.
    logic [DW-1:0] desc_mem [16];
    always @(posedge clk) if (desc_rd) desc_data <= desc_mem[desc_addr[3:0]];

    // Engine model: done 4 cycles after start unless the row is marked hung.
    logic [ACCW-1:0] model_val  [16];
    bit              model_hang [16];
    int              fetch_row = 0;
    int              eng_cnt = 0;
    bit              eng_active = 1'b0;
    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (desc_rd) fetch_row <= int'(desc_addr[3:0]);
        if (eng_start) begin
            eng_active      <= !model_hang[fetch_row];
            eng_cnt         <= 3;
            eng_acc_dequant <= model_val[fetch_row];
        end else if (eng_active) begin
            if (eng_cnt == 0) begin
                eng_done   <= 1'b1;
                eng_active <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    // Monitors sample mid-cycle.
    typedef struct packed {
        logic [RW-1:0]   row;
        logic [ACCW-1:0] data;
        logic            err;
    } out_rec_t;

    out_rec_t      out_q[$];
    logic [DW-1:0] start_q[$];
    int            n_done = 0;
    int            n_busy = 0;
    always @(negedge clk) begin
        if (eng_start) start_q.push_back({eng_weight_base, eng_nnz_pairs, eng_tail_idx, eng_scale});
        if (out_valid && out_ready) out_q.push_back('{out_row, out_data, out_err});
        if (layer_done) n_done <= n_done + 1;
        if (busy) n_busy <= n_busy + 1;
    end

    // Per-row stimulus and expected results.
    typedef struct {
        int              layer;
        logic [15:0]     nnz;
        logic [ACCW-1:0] val;
        bit              hang;
        logic [ACCW-1:0] exp_data;
        bit              exp_err;
    } vec_t;

    vec_t vt [10];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-row values of the currently loaded layer.
    logic [ACCW-1:0] exp_data_a [16];
    bit              exp_err_a  [16];
    logic [15:0]     exp_nnz_a  [16];

    task automatic load_layer(input int id, output int nrows, output int nlaunch);
        nrows = 0;
        nlaunch = 0;
        for (int i = 0; i < 10; i++) begin
            if (vt[i].layer == id) begin
                desc_mem[nrows]   = {AW'(12'h100 + nrows), vt[i].nnz, IW'(nrows * 3), SW'(24'h010000 + nrows)};
                model_val[nrows]  = vt[i].val;
                model_hang[nrows] = vt[i].hang;
                exp_data_a[nrows] = vt[i].exp_data;
                exp_err_a[nrows]  = vt[i].exp_err;
                exp_nnz_a[nrows]  = vt[i].nnz;
                if (vt[i].nnz != 0) nlaunch++;
                nrows++;
            end
        end
    endtask

    task automatic start_layer(input int n);
        num_rows    = RW'(n);
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
    endtask

    task automatic wait_layer_done(input string name, input int d0);
        int k;
        k = 0;
        while (n_done == d0 && k < 3000) begin
            tick();
            k++;
        end
        if (k >= 3000) check({name, " layer_done wait"}, 64'd0, 64'd1);
    endtask

    // Compare the outputs and launches recorded since the given snapshots.
    task automatic compare_layer(input string name, input int nrows, input int nlaunch,
                                 input int o0, input int s0);
        int j;
        bit any_err;
        check({name, " out count"}, 64'(out_q.size() - o0), 64'(nrows));
        check({name, " eng_start count"}, 64'(start_q.size() - s0), 64'(nlaunch));
        j = 0;
        any_err = 1'b0;
        for (int r = 0; r < nrows; r++) begin
            if (exp_err_a[r]) any_err = 1'b1;
            if (o0 + r < out_q.size())
                check($sformatf("%s row%0d result", name, r), 64'(out_q[o0 + r]),
                      64'({RW'(r), exp_data_a[r], exp_err_a[r]}));
            if (exp_nnz_a[r] != 0) begin
                if (s0 + j < start_q.size())
                    check($sformatf("%s row%0d descriptor", name, r), 64'(start_q[s0 + j]), 64'(desc_mem[r]));
                j++;
            end
        end
        check({name, " timeout_err"}, 64'(timeout_err), 64'(any_err));
    endtask

    task automatic run_and_check(input int id);
        int nrows, nl, o0, s0, d0;
        string name;
        name = $sformatf("L%0d", id);
        load_layer(id, nrows, nl);
        o0 = out_q.size();
        s0 = start_q.size();
        d0 = n_done;
        start_layer(nrows);
        wait_layer_done(name, d0);
        repeat (3) tick();
        check({name, " layer_done pulses"}, 64'(n_done - d0), 64'd1);
        check({name, " busy after done"}, 64'(busy), 64'd0);
        compare_layer(name, nrows, nl, o0, s0);
    endtask

    initial begin
        int nrows, nl, o0, s0, d0, b0, k, t_start, t_valid;

        vt[0] = '{0, 16'd4, 48'd100,             1'b0, 48'd100, 1'b0};
        vt[1] = '{0, 16'd1, 48'hFFFF_FFFF_FFCE,  1'b0, 48'd0,   1'b0};
        vt[2] = '{0, 16'd2, 48'd7,               1'b0, 48'd7,   1'b0};
        vt[3] = '{1, 16'd3, 48'd20,              1'b0, 48'd20,  1'b0};
        vt[4] = '{1, 16'd0, 48'd999,             1'b0, 48'd0,   1'b0};
        vt[5] = '{1, 16'd5, 48'h7FFF_FFFF_FFFF,  1'b0, 48'h7FFF_FFFF_FFFF, 1'b0};
        vt[6] = '{2, 16'd2, 48'd55,              1'b1, 48'd0,   1'b1};
        vt[7] = '{2, 16'd1, 48'd5,               1'b0, 48'd5,   1'b0};
        vt[8] = '{3, 16'd1, 48'd1,               1'b1, 48'd0,   1'b1};
        vt[9] = '{3, 16'd1, 48'd2,               1'b1, 48'd0,   1'b1};
        for (int i = 0; i < 16; i++) begin
            desc_mem[i]   = '0;
            model_val[i]  = '0;
            model_hang[i] = 1'b0;
        end

        // Reset state.
        repeat (3) tick();
        check("reset outputs", 64'({busy, layer_done, timeout_err, desc_rd, eng_start, out_valid, out_err}), 64'd0);
        check("reset eng/out regs", 64'({eng_nnz_pairs, eng_weight_base, out_row, desc_addr}), 64'd0);
        check("reset out_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        tick();

        // Table-driven layers: normal+ReLU, zero-nnz row, watchdog row.
        for (int id = 0; id < 3; id++) run_and_check(id);

        // Watchdog timing: EMIT 16 cycles after eng_start; layer_start clears sticky flag.
        load_layer(2, nrows, nl);
        d0 = n_done;
        start_layer(nrows);
        check("timeout_err cleared by layer_start", 64'(timeout_err), 64'd0);
        k = 0;
        while (!eng_start && k < 50) begin tick(); k++; end
        check("wd eng_start seen", 64'(eng_start), 64'd1);
        t_start = cyc;
        k = 0;
        while (!out_valid && k < 100) begin tick(); k++; end
        t_valid = cyc;
        check("wd emit latency", 64'(t_valid - t_start), 64'd16);
        check("wd result", 64'({out_valid, out_err, out_data}), {15'd0, 1'b1, 1'b1, 48'd0});
        check("wd timeout_err set", 64'(timeout_err), 64'd1);
        wait_layer_done("wd", d0);
        tick();
        check("wd timeout_err after layer", 64'(timeout_err), 64'd1);

        // Backpressure: result held 20 cycles, no further launch until accepted.
        load_layer(0, nrows, nl);
        o0 = out_q.size();
        s0 = start_q.size();
        d0 = n_done;
        out_ready = 1'b0;
        start_layer(nrows);
        k = 0;
        while (!out_valid && k < 100) begin tick(); k++; end
        for (int c = 0; c < 20; c++) begin
            check($sformatf("bp hold c%0d", c), 64'({out_valid, out_err, out_row, out_data}),
                  {5'd0, 1'b1, 1'b0, 10'd0, 48'd100});
            tick();
        end
        check("bp launches while stalled", 64'(start_q.size() - s0), 64'd1);
        out_ready = 1'b1;
        wait_layer_done("bp", d0);
        repeat (2) tick();
        compare_layer("bp", nrows, nl, o0, s0);

        // Abort during RUN of row 1 after row 0 timed out.
        load_layer(3, nrows, nl);
        s0 = start_q.size();
        d0 = n_done;
        start_layer(nrows);
        k = 0;
        while (start_q.size() - s0 < 2 && k < 200) begin tick(); k++; end
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy/out_valid", 64'({busy, out_valid}), 64'd0);
        check("abort timeout_err held", 64'(timeout_err), 64'd1);
        repeat (5) tick();
        check("abort no layer_done", 64'(n_done - d0), 64'd0);
        run_and_check(0);

        // Asynchronous reset between clock edges mid-RUN.
        load_layer(3, nrows, nl);
        start_layer(nrows);
        k = 0;
        while (!eng_start && k < 50) begin tick(); k++; end
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        check("async rst ctrl", 64'({busy, out_valid, timeout_err, eng_start, desc_rd, layer_done}), 64'd0);
        check("async rst eng regs", 64'({eng_nnz_pairs, eng_scale, eng_tail_idx}), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Empty layer: layer_done pulse next cycle, busy never high.
        d0 = n_done;
        b0 = n_busy;
        start_layer(0);
        check("zero rows layer_done", 64'(layer_done), 64'd1);
        tick();
        check("zero rows layer_done single", 64'(layer_done), 64'd0);
        repeat (2) tick();
        check("zero rows done count", 64'(n_done - d0), 64'd1);
        check("zero rows busy never", 64'(n_busy - b0), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
